// File: rtl/ysyx_201979054_m_pkg.sv
// rtl/ysyx_201979054_m_pkg.sv - shared constants and types for the M-extension units
package ysyx_201979054_m_pkg;

  // Bit positions inside the {word, rem, uns} operation code
  localparam int OP_WORD = 2;
  localparam int OP_REM  = 1;
  localparam int OP_UNS  = 0;

  // Iteration counts for full-width and word-width divides
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_e;

endpackage

// File: rtl/ysyx_201979054_div_step.sv
// rtl/ysyx_201979054_div_step.sv - one restoring shift/subtract iteration
module ysyx_201979054_div_step #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] div_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow;

  // Shift the next dividend bit into the partial remainder; keep the
  // difference only when the divisor fits. The shifted value can be one bit
  // wider than the divisor, but any kept difference is below the divisor, so
  // the low bits of a narrow subtraction are exact.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    borrow  = (shifted < {1'b0, div_i});
    diff    = shifted[DATA_WIDTH-1:0] - div_i;
    rem_o   = borrow ? shifted[DATA_WIDTH-1:0] : diff;
    quo_o   = {quo_i[DATA_WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// rtl/ysyx_201979054_div_unit.sv - iterative radix-2 divider for the RV64M divide group
module ysyx_201979054_div_unit
  import ysyx_201979054_m_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic                  i_kill,
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int HW = DATA_WIDTH - WORD_WIDTH;

  // Word results are always sign-extended from bit 31, unsigned ones included
  function automatic logic [DATA_WIDTH-1:0] word_fmt(input logic [DATA_WIDTH-1:0] v,
                                                     input logic word);
    return word ? {{HW{v[WORD_WIDTH-1]}}, v[WORD_WIDTH-1:0]} : v;
  endfunction

  div_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  word_q, word_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic [DATA_WIDTH-1:0] ext_1, ext_2, mag_1, mag_2, min_val, special_res;
  logic                  in_word, in_uns, neg_1, neg_2, div_zero, sgn_ovf;
  logic [DATA_WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix, post_res;

  ysyx_201979054_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  // Operand conditioning at accept: width selection, magnitudes, special cases
  always_comb begin
    in_word     = i_op[OP_WORD];
    in_uns      = i_op[OP_UNS];
    ext_1       = in_word ? {{HW{~in_uns & i_src_1[WORD_WIDTH-1]}}, i_src_1[WORD_WIDTH-1:0]}
                          : i_src_1;
    ext_2       = in_word ? {{HW{~in_uns & i_src_2[WORD_WIDTH-1]}}, i_src_2[WORD_WIDTH-1:0]}
                          : i_src_2;
    neg_1       = ~in_uns & ext_1[DATA_WIDTH-1];
    neg_2       = ~in_uns & ext_2[DATA_WIDTH-1];
    mag_1       = neg_1 ? -ext_1 : ext_1;
    mag_2       = neg_2 ? -ext_2 : ext_2;
    min_val     = in_word ? {{(HW + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}}
                          : {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    div_zero    = (ext_2 == {DATA_WIDTH{1'b0}});
    sgn_ovf     = ~in_uns & (ext_1 == min_val) & (ext_2 == {DATA_WIDTH{1'b1}});
    if (div_zero) begin
      special_res = i_op[OP_REM] ? ext_1 : {DATA_WIDTH{1'b1}};
    end else begin
      special_res = i_op[OP_REM] ? {DATA_WIDTH{1'b0}} : ext_1;
    end
  end

  // Sign correction and word extension of the final iteration's outputs
  always_comb begin
    quo_fix  = neg_quo_q ? -step_quo : step_quo;
    rem_fix  = neg_rem_q ? -step_rem : step_rem;
    post_res = word_fmt(is_rem_q ? rem_fix : quo_fix, word_q);
  end

  // Next-state and datapath update for IDLE/CALC/FIN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    word_d    = word_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_kill) begin
          word_d    = in_word;
          is_rem_d  = i_op[OP_REM];
          neg_quo_d = neg_1 ^ neg_2;
          neg_rem_d = neg_1;
          rem_d     = '0;
          div_d     = mag_2;
          // Word dividends sit in the top half so the quotient lands in the low half
          quo_d     = in_word ? (mag_1 << WORD_WIDTH) : mag_1;
          cnt_d     = in_word ? CW'(DIV_ITER_32) : CW'(DIV_ITER_64);
          if (div_zero || sgn_ovf) begin
            result_d = word_fmt(special_res, in_word);
            state_d  = FIN;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (i_kill) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_d = post_res;
            state_d  = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      word_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      word_q    <= word_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == FIN) && !i_kill;
  assign o_result = result_q;

endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
// tb/tb_ysyx_201979054_div_unit.sv - self-checking bench for the iterative divider
module tb_ysyx_201979054_div_unit;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_kill = 1'b0;
  logic [2:0]  i_op = 3'b000;
  logic [63:0] i_src_1 = 64'd0;
  logic [63:0] i_src_2 = 64'd0;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_result;

  int checks = 0;
  int passed = 0;

  ysyx_201979054_div_unit dut (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_start (i_start),
    .i_kill  (i_kill),
    .i_op    (i_op),
    .i_src_1 (i_src_1),
    .i_src_2 (i_src_2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // RISC-V divide/remainder semantics straight from the ISA rules
  function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    if (op[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)                                                r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
      else if (op[0])                                                  r32 = op[1] ? a32 % b32 : a32 / b32;
      else r32 = op[1] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                                  r = op[1] ? a : '1;
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)      r = op[1] ? 64'd0 : a;
      else if (op[0])                                                  r = op[1] ? a % b : a / b;
      else r = op[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    end
    return r;
  endfunction

  // Cycles from accept to the done cycle, minus one: zero for the shortcut cases
  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (op[2]) begin
      zero = (b[31:0] == 32'd0);
      ovf  = !op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
      return (zero || ovf) ? 0 : 32;
    end
    zero = (b == 64'd0);
    ovf  = !op[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    return (zero || ovf) ? 0 : 64;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge i_clk);
    i_op    = op;
    i_src_1 = a;
    i_src_2 = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_op    = 3'($urandom);
    i_src_1 = {$urandom, $urandom};
    i_src_2 = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    bit seen;
    issue(op, a, b);
    wait_done(lat, seen);
    check({tag, " done"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, o_result, exp_res);
    check({tag, " busy_fin"}, 64'(o_busy), 64'd1);
    @(negedge i_clk);
    check({tag, " idle_after"}, {62'd0, o_done, o_busy}, 64'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    int dcount;
    logic [2:0]  op;
    logic [63:0] a, b;

    #1 i_arst = 1'b1;
    #1;
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset result", o_result, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;

    run_op("divu", 3'b001, 64'd100, 64'd7, 64'd14, 64);
    run_op("remu", 3'b011, 64'd100, 64'd7, 64'd2, 64);
    run_op("rem_neg", 3'b010, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("div_neg", 3'b000, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    run_op("div_zero", 3'b000, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu_zero", 3'b011, 64'd5, 64'd0, 64'd5, 0);
    run_op("divw_ovf", 3'b100, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("div_ovf", 3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 0);
    run_op("remw_neg", 3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    run_op("divuw_sext", 3'b101, 64'h1234_5678_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 32);

    // A second start while busy must not disturb the operation in flight
    issue(3'b001, 64'd1000, 64'd3);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (k == 9) begin
        i_start = 1'b1;
        i_op    = 3'b000;
        i_src_1 = 64'd7;
        i_src_2 = 64'd0;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("busy_start done", 64'(seen), 64'd1);
    check("busy_start cycle", 64'(lat), 64'd65);
    check("busy_start result", o_result, 64'd333);
    @(negedge i_clk);

    // Kill mid-calculation: back to idle, no pulse, result untouched
    issue(3'b001, 64'd999, 64'd2);
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (k == 20) i_kill = 1'b1;
    end
    @(negedge i_clk);
    i_kill = 1'b0;
    check("kill busy", 64'(o_busy), 64'd0);
    dcount = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge i_clk);
      if (o_done) dcount++;
    end
    check("kill no_done", 64'(dcount), 64'd0);
    check("kill result_held", o_result, 64'd333);

    // Kill together with start in IDLE: request dropped
    @(negedge i_clk);
    i_op    = 3'b001;
    i_src_1 = 64'd9;
    i_src_2 = 64'd3;
    i_start = 1'b1;
    i_kill  = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_kill  = 1'b0;
    check("kill_start busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    check("kill_start busy2", 64'(o_busy), 64'd0);

    // Asynchronous reset mid-operation
    issue(3'b000, -64'sd100, 64'd7);
    for (int k = 1; k < 30; k++) @(negedge i_clk);
    i_arst = 1'b1;
    #1;
    check("arst busy", 64'(o_busy), 64'd0);
    check("arst done", 64'(o_done), 64'd0);
    check("arst result", o_result, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    run_op("divuw_post_rst", 3'b101, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 32);

    // Randomized operations against the reference model
    for (int n = 0; n < 28; n++) begin
      op = 3'($urandom);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: a = a >> $urandom_range(0, 60);
        1: a = op[2] ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        default: ;
      endcase
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = 64'hFFFF_FFFF_FFFF_FFFF;
        2: b = 64'($urandom_range(1, 20));
        3: b = b >> $urandom_range(1, 62);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", n, op), op, a, b, ref_div(op, a, b), ref_lat(op, a, b));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
